dm_lane: RTL

- Parametrised data memory that succeeds the fixed 1K-word, word-only DM in the single-cycle/multi-cycle CPU datapath.
- Adds byte/halfword stores and loads, sign/zero extension, a configurable depth and base address, alignment and range checking, and a sticky fault flag.
- Clears memory with a one-word-per-cycle sweep state machine on reset or on request, instead of a single-cycle bulk clear.
- Sits between the ALU result (address), the rt register (store data) and the write-back mux.

---
 rtl/dm_lane.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/dm_lane.sv
// dm_lane: parametrised byte-addressable data memory for the CPU datapath.
// Supports word/half/byte stores and loads with sign/zero extension, a base
// address window with range and alignment checks, a sticky store-fault flag
// and a one-word-per-cycle clear sweep after reset or on request.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-low
//   memaddr    byte address
//   wd         store data, right-justified for byte/half stores
//   memwrite   store strobe
//   op         access size: 00 word, 01 half, 10 byte, 11 word
//   sext       loads: 1 sign-extend, 0 zero-extend
//   clr        request a full clear sweep (honoured only when idle)
//   data       combinational load data
//   ready      1 when idle and accepting stores
//   align_err  combinational misalignment indication
//   range_err  combinational out-of-range indication
//   fault      sticky: a store was suppressed
module dm_lane #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] memaddr,
    input  logic [31:0] wd,
    input  logic        memwrite,
    input  logic [1:0]  op,
    input  logic        sext,
    input  logic        clr,
    output logic [31:0] data,
    output logic        ready,
    output logic        align_err,
    output logic        range_err,
    output logic        fault
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned IDX_W = DEPTH_LOG2;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    localparam logic [1:0] OP_HALF = 2'b01;
    localparam logic [1:0] OP_BYTE = 2'b10;

    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(DEPTH - 1);

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_ptr;
    logic             r_fault;
    logic [31:0]      r_mem [DEPTH];

    logic [0:0]       w_state_nxt;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic             w_fault_nxt;
    logic             w_clr_we;
    logic             w_st_we;

    logic [31:0]      w_off;
    logic             w_in_range;
    logic [IDX_W-1:0] w_idx;
    logic             w_is_half;
    logic             w_is_byte;
    logic             w_align_err;
    logic             w_ready;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_word;
    logic [15:0]      w_half;
    logic [7:0]       w_byte;

    // Address decode: offset from base, window check, word index.
    always_comb begin
        w_off      = memaddr - BASE_ADDR;
        w_in_range = ((w_off >> (DEPTH_LOG2 + 2)) == 32'd0);
        w_idx      = w_off[DEPTH_LOG2+1:2];
        w_is_half  = (op == OP_HALF);
        w_is_byte  = (op == OP_BYTE);
        // Reserved op 11 behaves as word.
        if (w_is_byte)
            w_align_err = 1'b0;
        else if (w_is_half)
            w_align_err = memaddr[0];
        else
            w_align_err = (memaddr[1:0] != 2'b00);
    end

    assign w_ready   = (r_state == ST_IDLE);
    assign ready     = w_ready;
    assign align_err = w_align_err;
    assign range_err = !w_in_range;
    assign fault     = r_fault;

    // Lane enables and lane-replicated store data.
    always_comb begin
        if (w_is_byte) begin
            w_be    = 4'(4'b0001 << memaddr[1:0]);
            w_wdata = {4{wd[7:0]}};
        end else if (w_is_half) begin
            w_be    = memaddr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{wd[15:0]}};
        end else begin
            w_be    = 4'b1111;
            w_wdata = wd;
        end
    end

    // Next-state logic for the clear sweep / idle machine.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_fault_nxt = r_fault;
        w_clr_we    = 1'b0;
        w_st_we     = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                // clr and memwrite are ignored while sweeping.
                w_clr_we  = 1'b1;
                w_ptr_nxt = r_ptr + IDX_W'(1);
                if (r_ptr == LAST_PTR)
                    w_state_nxt = ST_IDLE;
            end
            default: begin
                if (clr) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                    w_fault_nxt = 1'b0;
                end else if (memwrite) begin
                    if (w_in_range && !w_align_err)
                        w_st_we = 1'b1;
                    else
                        w_fault_nxt = 1'b1;
                end
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    // Array writes: sweep zeroing or lane-masked store; none during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (w_clr_we) begin
                r_mem[r_ptr] <= 32'd0;
            end else if (w_st_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_be[i])
                        r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    // Combinational load path (sees pre-store contents within a cycle).
    always_comb begin
        w_word = r_mem[w_idx];
        w_half = memaddr[1] ? w_word[31:16] : w_word[15:0];
        case (memaddr[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        data = 32'd0;
        if (w_ready && w_in_range && !w_align_err) begin
            if (w_is_byte)
                data = {{24{sext & w_byte[7]}}, w_byte};
            else if (w_is_half)
                data = {{16{sext & w_half[15]}}, w_half};
            else
                data = w_word;
        end
    end

endmodule
